// File: rtl/vga_pkg.sv
// Shared VGA timing constants, framebuffer geometry and the
// per-cycle RAM port grant encoding.
package vga_pkg;

  localparam int H_SYNC  = 80;
  localparam int H_BACK  = 160;
  localparam int H_ACT   = 800;
  localparam int H_TOTAL = 1056;

  localparam int V_SYNC  = 3;
  localparam int V_BACK  = 21;
  localparam int V_ACT   = 600;
  localparam int V_TOTAL = 625;

  localparam int CELL = 8;
  localparam int COLS = 100;
  localparam int ROWS = 75;
  localparam int AW   = 13;

  typedef enum logic [1:0] {
    IDLE,
    VID,
    WR
  } grant_e;

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Writer request channel plus the single framebuffer RAM port.
// The arbiter is the slave of the writer and drives the RAM.
interface vga_fb_arbiter_if;
  import vga_pkg::*;

  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [2:0]    wr_data;
  logic          wr_ack;
  logic          wr_err;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [2:0]    mem_wdata;
  logic [2:0]    mem_rdata;

  modport slave (
    input  wr_req, wr_addr, wr_data,
    output wr_ack, wr_err,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output wr_req, wr_addr, wr_data,
    input  wr_ack, wr_err,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/vga_timing.sv
// Free-running x/y raster counters with sync and active-window flags.
module vga_timing #(
  parameter int H_SYNC  = vga_pkg::H_SYNC,
  parameter int H_BACK  = vga_pkg::H_BACK,
  parameter int H_ACT   = vga_pkg::H_ACT,
  parameter int H_TOTAL = vga_pkg::H_TOTAL,
  parameter int V_SYNC  = vga_pkg::V_SYNC,
  parameter int V_BACK  = vga_pkg::V_BACK,
  parameter int V_ACT   = vga_pkg::V_ACT,
  parameter int V_TOTAL = vga_pkg::V_TOTAL,
  parameter int XW      = $clog2(H_TOTAL),
  parameter int YW      = $clog2(V_TOTAL)
) (
  input  logic          clk_vga,
  input  logic          rst,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          hsync,
  output logic          vsync,
  output logic          active
);

  localparam int XS = H_SYNC + H_BACK;
  localparam int YS = V_SYNC + V_BACK;

  logic [XW-1:0] x_d, x_q;
  logic [YW-1:0] y_d, y_q;
  logic          x_end, y_end;

  always_comb begin
    x_end = (x_q == XW'(H_TOTAL - 1));
    y_end = (y_q == YW'(V_TOTAL - 1));
    x_d   = x_end ? '0 : x_q + XW'(1);
    y_d   = y_q;
    if (x_end) begin
      y_d = y_end ? '0 : y_q + YW'(1);
    end
  end

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign hsync  = (x_q >= XW'(H_SYNC));
  assign vsync  = (y_q >= YW'(V_SYNC));
  assign active = (x_q >= XW'(XS)) && (x_q < XW'(XS + H_ACT)) &&
                  (y_q >= YW'(YS)) && (y_q < YW'(YS + V_ACT));

endmodule

// File: rtl/vga_fb_arbiter.sv
// Framebuffer arbiter: one RAM port shared between scan-out reads,
// which always win, and single-cycle writer requests.
module vga_fb_arbiter #(
  parameter int H_SYNC  = vga_pkg::H_SYNC,
  parameter int H_BACK  = vga_pkg::H_BACK,
  parameter int H_ACT   = vga_pkg::H_ACT,
  parameter int H_TOTAL = vga_pkg::H_TOTAL,
  parameter int V_SYNC  = vga_pkg::V_SYNC,
  parameter int V_BACK  = vga_pkg::V_BACK,
  parameter int V_ACT   = vga_pkg::V_ACT,
  parameter int V_TOTAL = vga_pkg::V_TOTAL,
  parameter int CELL    = vga_pkg::CELL,
  parameter int COLS    = vga_pkg::COLS,
  parameter int ROWS    = vga_pkg::ROWS,
  parameter int AW      = vga_pkg::AW
) (
  input  logic            clk_vga,
  input  logic            rst,
  vga_fb_arbiter_if.slave bus,
  output logic            hsync,
  output logic            vsync,
  output logic [3:0]      vgared,
  output logic [3:0]      vgagreen,
  output logic [3:0]      vgablue
);
  import vga_pkg::*;

  localparam int XW    = $clog2(H_TOTAL);
  localparam int YW    = $clog2(V_TOTAL);
  localparam int XS    = H_SYNC + H_BACK;
  localparam int YS    = V_SYNC + V_BACK;
  localparam int SH    = $clog2(CELL);
  localparam int SPAN  = COLS * CELL;
  localparam int CELLS = COLS * ROWS;

  logic [XW-1:0] x, xo;
  logic [YW-1:0] y, yo;
  logic          t_hs, t_vs, active, show;
  logic          y_act, slot, in_range;
  logic [AW-1:0] vid_addr, addr_d, addr_q;
  logic [2:0]    wdata_d, wdata_q, pix_d, pix_q;
  logic          vid_d, vid_q;
  logic          mem_en, mem_we, wr_ack, wr_err;
  grant_e        grant;

  vga_timing #(
    .H_SYNC (H_SYNC),
    .H_BACK (H_BACK),
    .H_ACT  (H_ACT),
    .H_TOTAL(H_TOTAL),
    .V_SYNC (V_SYNC),
    .V_BACK (V_BACK),
    .V_ACT  (V_ACT),
    .V_TOTAL(V_TOTAL),
    .XW     (XW),
    .YW     (YW)
  ) u_timing (
    .clk_vga(clk_vga),
    .rst    (rst),
    .x      (x),
    .y      (y),
    .hsync  (t_hs),
    .vsync  (t_vs),
    .active (active)
  );

  // Fetch cell n two cycles ahead so it lands in pix_q on time.
  always_comb begin
    xo    = x - XW'(XS - 2);
    yo    = y - YW'(YS);
    y_act = (y >= YW'(YS)) && (y < YW'(YS + V_ACT));
    slot  = y_act && (x >= XW'(XS - 2)) &&
            (xo < XW'(SPAN)) && (xo[SH-1:0] == '0);
    vid_addr = AW'(yo >> SH) * AW'(COLS) + AW'(xo >> SH);
  end

  always_comb begin
    grant = IDLE;
    if (rst) begin
      grant = IDLE;
    end else if (slot) begin
      grant = VID;
    end else if (bus.wr_req) begin
      grant = WR;
    end
  end

  always_comb begin
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    wr_ack   = 1'b0;
    wr_err   = 1'b0;
    in_range = (bus.wr_addr < AW'(CELLS));
    unique case (grant)
      VID: begin
        mem_en = 1'b1;
        addr_d = vid_addr;
      end
      WR: begin
        wr_ack = 1'b1;
        if (in_range) begin
          mem_en  = 1'b1;
          mem_we  = 1'b1;
          addr_d  = bus.wr_addr;
          wdata_d = bus.wr_data;
        end else begin
          wr_err = 1'b1;
        end
      end
      default: ;
    endcase
    if (rst) begin
      addr_d  = '0;
      wdata_d = '0;
    end
  end

  always_comb begin
    vid_d = (grant == VID);
    pix_d = vid_q ? bus.mem_rdata : pix_q;
  end

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      pix_q   <= '0;
      vid_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      pix_q   <= pix_d;
      vid_q   <= vid_d;
    end
  end

  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = addr_d;
  assign bus.mem_wdata = wdata_d;
  assign bus.wr_ack    = wr_ack;
  assign bus.wr_err    = wr_err;

  assign show     = active & ~rst;
  assign hsync    = t_hs & ~rst;
  assign vsync    = t_vs & ~rst;
  assign vgared   = {4{show & pix_q[2]}};
  assign vgagreen = {4{show & pix_q[1]}};
  assign vgablue  = {4{show & pix_q[0]}};

endmodule
